// File: rtl/cnn_pkg.sv
// Shared types and dimensions for the binarized CNN layer sequencer.
package cnn_pkg;

   localparam int unsigned N_CH       = 6;
   localparam int unsigned FMAP_DEPTH = 144;
   localparam int unsigned IMG_WORDS  = 784;
   localparam int unsigned W_WORDS    = 25;
   localparam int unsigned AW         = 8;
   localparam int unsigned BW         = 5;   // weight beat counter
   localparam int unsigned CW         = 3;   // channel counter
   localparam int unsigned IW         = 10;  // image beat counter

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_W1 = 3'd1,
      ST_CONV_1  = 3'd2,
      ST_LOAD_W2 = 3'd3,
      ST_CONV_2  = 3'd4,
      ST_FC      = 3'd5,
      ST_FIN     = 3'd6
   } state_e;

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Control/handshake bundle between the sequencer (master) and the datapath (slave).
interface cnn_layer_sequencer_if;
   import cnn_pkg::*;

   logic                 start;
   logic                 din_valid;
   logic                 din_ready;
   logic [N_CH-1:0]      weight_en;
   logic                 weight_c;
   logic                 conv_start;
   logic                 conv_layer;
   logic [N_CH-1:0]      conv_ovalid;
   logic [N_CH-1:0]      conv_done;
   logic [N_CH-1:0]      fmap_we;
   logic [AW*N_CH-1:0]   fmap_waddr;
   logic [AW-1:0]        fmap_raddr;
   logic                 fmap_rvalid;
   logic                 fc_start;
   logic                 fc_done;
   logic                 busy;
   logic                 done;

   modport master (
      input  start, din_valid, conv_ovalid, conv_done, fc_done,
      output din_ready, weight_en, weight_c, conv_start, conv_layer, fmap_we,
             fmap_waddr, fmap_raddr, fmap_rvalid, fc_start, busy, done
   );

   modport slave (
      output start, din_valid, conv_ovalid, conv_done, fc_done,
      input  din_ready, weight_en, weight_c, conv_start, conv_layer, fmap_we,
             fmap_waddr, fmap_raddr, fmap_rvalid, fc_start, busy, done
   );

endinterface

// File: rtl/fmap_wptr.sv
// Per-channel fmap write pointer: wraps at FMAP_DEPTH-1, clear has priority.
module fmap_wptr
   import cnn_pkg::*;
(
   input  logic          clk,
   input  logic          rstn,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [AW-1:0] wptr_o
);

   logic [AW-1:0] wptr_q, wptr_d;

   always_comb begin
      wptr_d = wptr_q;
      if (clr_i)
         wptr_d = '0;
      else if (inc_i)
         wptr_d = (wptr_q == AW'(FMAP_DEPTH - 1)) ? '0 : wptr_q + AW'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) wptr_q <= '0;
      else       wptr_q <= wptr_d;
   end

   assign wptr_o = wptr_q;

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Layer sequencer: weight load, conv streaming/replay, done gathering, FC handoff.
module cnn_layer_sequencer
   import cnn_pkg::*;
(
   input  logic                  clk,
   input  logic                  rstn,
   cnn_layer_sequencer_if.master bus
);

   state_e          state_q, state_d;
   logic [BW-1:0]   b_q, b_d;
   logic [CW-1:0]   c_q, c_d;
   logic [IW-1:0]   img_q, img_d;
   logic [AW-1:0]   raddr_q, raddr_d;
   logic            rvalid_q, rvalid_d;
   logic [N_CH-1:0] mask_q, mask_d;
   logic            weight_c_q, weight_c_d;
   logic            conv_start_q, conv_start_d;
   logic            fc_start_q, fc_start_d;
   logic            wp_clr;
   logic            in_load, in_conv, accept, last_w, layer_done;
   logic [N_CH-1:0] mask_all;
   logic [AW-1:0]   wp [N_CH];

   assign in_load    = (state_q == ST_LOAD_W1) || (state_q == ST_LOAD_W2);
   assign in_conv    = (state_q == ST_CONV_1)  || (state_q == ST_CONV_2);
   assign accept     = bus.din_valid && bus.din_ready;
   assign last_w     = in_load && accept && (c_q == CW'(N_CH - 1)) && (b_q == BW'(W_WORDS - 1));
   // Done bits arriving this cycle count toward the decision.
   assign mask_all   = mask_q | bus.conv_done;
   assign layer_done = in_conv && (&mask_all);

   always_comb begin
      state_d      = state_q;
      b_d          = b_q;
      c_d          = c_q;
      img_d        = img_q;
      raddr_d      = raddr_q;
      rvalid_d     = 1'b0;
      mask_d       = mask_q;
      weight_c_d   = 1'b0;
      conv_start_d = 1'b0;
      fc_start_d   = 1'b0;
      wp_clr       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_LOAD_W1;
               b_d     = '0;
               c_d     = '0;
               img_d   = '0;
               raddr_d = '0;
               mask_d  = '0;
               wp_clr  = 1'b1;
            end
         end
         ST_LOAD_W1, ST_LOAD_W2: begin
            if (accept) begin
               if (b_q == BW'(W_WORDS - 1)) begin
                  b_d = '0;
                  c_d = c_q + CW'(1);
               end else begin
                  b_d = b_q + BW'(1);
               end
            end
            if (last_w) begin
               state_d      = (state_q == ST_LOAD_W1) ? ST_CONV_1 : ST_CONV_2;
               c_d          = '0;
               img_d        = '0;
               raddr_d      = '0;
               mask_d       = '0;
               wp_clr       = 1'b1;
               weight_c_d   = 1'b1;
               conv_start_d = 1'b1;
            end
         end
         ST_CONV_1: begin
            if (accept) img_d = img_q + IW'(1);
            mask_d = mask_all;
            if (layer_done) begin
               state_d = ST_LOAD_W2;
               b_d     = '0;
               c_d     = '0;
            end
         end
         ST_CONV_2: begin
            mask_d = mask_all;
            // Replay starts the cycle after conv_start and parks on the last entry.
            if (conv_start_q) begin
               rvalid_d = 1'b1;
               raddr_d  = '0;
            end else if (rvalid_q && (raddr_q != AW'(FMAP_DEPTH - 1))) begin
               rvalid_d = 1'b1;
               raddr_d  = raddr_q + AW'(1);
            end
            if (layer_done) begin
               state_d    = ST_FC;
               fc_start_d = 1'b1;
               rvalid_d   = 1'b0;
            end
         end
         ST_FC:   if (bus.fc_done) state_d = ST_FIN;
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         b_q          <= '0;
         c_q          <= '0;
         img_q        <= '0;
         raddr_q      <= '0;
         rvalid_q     <= 1'b0;
         mask_q       <= '0;
         weight_c_q   <= 1'b0;
         conv_start_q <= 1'b0;
         fc_start_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         b_q          <= b_d;
         c_q          <= c_d;
         img_q        <= img_d;
         raddr_q      <= raddr_d;
         rvalid_q     <= rvalid_d;
         mask_q       <= mask_d;
         weight_c_q   <= weight_c_d;
         conv_start_q <= conv_start_d;
         fc_start_q   <= fc_start_d;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_wptr
      fmap_wptr u_wptr (
         .clk    (clk),
         .rstn   (rstn),
         .clr_i  (wp_clr),
         .inc_i  (in_conv && bus.conv_ovalid[i]),
         .wptr_o (wp[i])
      );
      assign bus.fmap_waddr[i*AW +: AW] = wp[i];
   end

   assign bus.din_ready   = in_load || ((state_q == ST_CONV_1) && (img_q < IW'(IMG_WORDS)));
   assign bus.weight_en   = (in_load && accept) ? (N_CH'(1) << c_q) : '0;
   assign bus.fmap_we     = in_conv ? bus.conv_ovalid : '0;
   assign bus.fmap_raddr  = raddr_q;
   assign bus.fmap_rvalid = rvalid_q;
   assign bus.weight_c    = weight_c_q;
   assign bus.conv_start  = conv_start_q;
   assign bus.fc_start    = fc_start_q;
   assign bus.conv_layer  = (state_q == ST_LOAD_W2) || (state_q == ST_CONV_2);
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.done        = (state_q == ST_FIN);

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed self-checking bench for cnn_layer_sequencer.
module tb_cnn_layer_sequencer;
   import cnn_pkg::*;

   logic clk = 1'b0;
   logic rstn;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   we_pulses = 0;
   int   done_pulses = 0;

   cnn_layer_sequencer_if bus();

   cnn_layer_sequencer dut (.clk(clk), .rstn(rstn), .bus(bus));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.weight_en != '0) we_pulses++;
      if (bus.done) done_pulses++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start       = 1'b0;
      bus.din_valid   = 1'b0;
      bus.conv_ovalid = '0;
      bus.conv_done   = '0;
      bus.fc_done     = 1'b0;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   // 150 back-to-back beats; returns positioned on the first conv cycle.
   task automatic load_weights();
      for (int k = 0; k < int'(N_CH * W_WORDS); k++) begin
         bus.din_valid = 1'b1;
         tick();
      end
      bus.din_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [75:0] outs;
      rstn = 1'b0;
      idle_inputs();
      bus.conv_ovalid = '1;
      bus.din_valid   = 1'b1;
      repeat (2) tick();
      #1;
      outs = {bus.din_ready, bus.weight_en, bus.weight_c, bus.conv_start, bus.conv_layer,
              bus.fmap_we, bus.fmap_waddr, bus.fmap_raddr, bus.fmap_rvalid, bus.fc_start,
              bus.busy, bus.done};
      n_tests++;
      if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
      n_tests++;
      if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
      idle_inputs();
      rstn = 1'b1;
      tick();
      n_tests++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", bus.busy); end
   endtask

   task automatic test_full();
      logic [N_CH-1:0] exp_we;
      int we0, dn0;
      we0 = we_pulses;
      dn0 = done_pulses;
      bus.start = 1'b1;
      #1;
      n_tests++;
      if ({bus.busy, bus.din_ready} !== 2'b00) begin n_fail++; $display("FAIL start_same_cycle: got %b expected 00", {bus.busy, bus.din_ready}); end
      tick();
      bus.start = 1'b0;
      #1;
      n_tests++;
      if ({dut.state_q, bus.busy, bus.din_ready} !== {ST_LOAD_W1, 2'b11}) begin
         n_fail++; $display("FAIL start_next: got st=%0d busy=%b rdy=%b expected st=1 busy=1 rdy=1", dut.state_q, bus.busy, bus.din_ready);
      end
      for (int k = 0; k < 150; k++) begin
         bus.din_valid = 1'b1;
         #1;
         exp_we = N_CH'(1) << (k / 25);
         n_tests++;
         if (bus.weight_en !== exp_we) begin n_fail++; $display("FAIL w1_weight_en[%0d]: got %b expected %b", k, bus.weight_en, exp_we); end
         tick();
      end
      #1;
      n_tests++;
      if ({dut.state_q, bus.weight_c, bus.conv_start, bus.conv_layer, bus.din_ready} !== {ST_CONV_1, 4'b1101}) begin
         n_fail++; $display("FAIL conv1_entry: got st=%0d wc=%b cs=%b layer=%b rdy=%b expected st=2 1 1 0 1",
                            dut.state_q, bus.weight_c, bus.conv_start, bus.conv_layer, bus.din_ready);
      end
      for (int j = 0; j <= 784; j++) begin
         bus.din_valid = 1'b1;
         #1;
         if (j == 1) begin
            n_tests++;
            if ({bus.weight_c, bus.conv_start, bus.weight_en} !== 8'h00) begin
               n_fail++; $display("FAIL conv1_pulses_clear: got wc=%b cs=%b we=%b expected 0", bus.weight_c, bus.conv_start, bus.weight_en);
            end
         end
         if (j == 783) begin
            n_tests++;
            if (bus.din_ready !== 1'b1) begin n_fail++; $display("FAIL img_last_ready: got %b expected 1", bus.din_ready); end
         end
         if (j == 784) begin
            n_tests++;
            if (bus.din_ready !== 1'b0) begin n_fail++; $display("FAIL img_full_ready: got %b expected 0", bus.din_ready); end
         end
         tick();
      end
      bus.din_valid = 1'b0;
      bus.conv_done = '1;
      #1;
      n_tests++;
      if (dut.state_q !== ST_CONV_1) begin n_fail++; $display("FAIL conv1_hold: got %0d expected %0d", dut.state_q, ST_CONV_1); end
      tick();
      bus.conv_done = '0;
      #1;
      n_tests++;
      if ({dut.state_q, bus.conv_layer, bus.din_ready} !== {ST_LOAD_W2, 2'b11}) begin
         n_fail++; $display("FAIL load_w2_entry: got st=%0d layer=%b rdy=%b expected st=3 1 1", dut.state_q, bus.conv_layer, bus.din_ready);
      end
      load_weights();
      #1;
      n_tests++;
      if ({dut.state_q, bus.conv_start, bus.weight_c, bus.fmap_rvalid, bus.din_ready} !== {ST_CONV_2, 4'b1100}) begin
         n_fail++; $display("FAIL conv2_entry: got st=%0d cs=%b wc=%b rv=%b rdy=%b expected st=4 1 1 0 0",
                            dut.state_q, bus.conv_start, bus.weight_c, bus.fmap_rvalid, bus.din_ready);
      end
      for (int j = 1; j <= 150; j++) begin
         tick();
         if (j == 150) bus.conv_done = '1;
         #1;
         if (j == 1) begin
            n_tests++;
            if ({bus.fmap_rvalid, bus.fmap_raddr} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL replay_first: got rv=%b ra=%0d expected 1 0", bus.fmap_rvalid, bus.fmap_raddr); end
         end
         if (j == 144) begin
            n_tests++;
            if ({bus.fmap_rvalid, bus.fmap_raddr} !== {1'b1, 8'd143}) begin n_fail++; $display("FAIL replay_last: got rv=%b ra=%0d expected 1 143", bus.fmap_rvalid, bus.fmap_raddr); end
         end
         if (j == 145) begin
            n_tests++;
            if ({bus.fmap_rvalid, bus.fmap_raddr} !== {1'b0, 8'd143}) begin n_fail++; $display("FAIL replay_park: got rv=%b ra=%0d expected 0 143", bus.fmap_rvalid, bus.fmap_raddr); end
         end
      end
      tick();
      bus.conv_done = '0;
      #1;
      n_tests++;
      if ({dut.state_q, bus.fc_start} !== {ST_FC, 1'b1}) begin n_fail++; $display("FAIL fc_entry: got st=%0d fcs=%b expected st=5 1", dut.state_q, bus.fc_start); end
      for (int j = 1; j <= 10; j++) begin
         tick();
         if (j == 10) bus.fc_done = 1'b1;
         #1;
         if (j == 1) begin
            n_tests++;
            if ({dut.state_q, bus.fc_start, bus.done} !== {ST_FC, 2'b00}) begin n_fail++; $display("FAIL fc_wait: got st=%0d fcs=%b done=%b expected st=5 0 0", dut.state_q, bus.fc_start, bus.done); end
         end
      end
      tick();
      bus.fc_done = 1'b0;
      #1;
      n_tests++;
      if ({dut.state_q, bus.done, bus.busy} !== {ST_FIN, 2'b11}) begin n_fail++; $display("FAIL fin: got st=%0d done=%b busy=%b expected st=6 1 1", dut.state_q, bus.done, bus.busy); end
      tick();
      #1;
      n_tests++;
      if ({dut.state_q, bus.done, bus.busy} !== {ST_IDLE, 2'b00}) begin n_fail++; $display("FAIL back_idle: got st=%0d done=%b busy=%b expected st=0 0 0", dut.state_q, bus.done, bus.busy); end
      @(negedge clk);
      #1;
      n_tests++;
      if (we_pulses - we0 !== 300) begin n_fail++; $display("FAIL weight_en_count: got %0d expected 300", we_pulses - we0); end
      n_tests++;
      if (done_pulses - dn0 !== 1) begin n_fail++; $display("FAIL done_count: got %0d expected 1", done_pulses - dn0); end
      tick();
   endtask

   task automatic test_wrap();
      logic [AW*N_CH-1:0] exp_wa;
      do_start();
      load_weights();
      for (int p = 0; p < 149; p++) begin
         bus.conv_ovalid = 6'b000100;
         bus.start       = (p == 10);
         bus.conv_done   = (p == 148) ? 6'b000100 : 6'b000000;
         #1;
         if (p == 0) begin
            n_tests++;
            if ({bus.fmap_we, bus.fmap_waddr} !== {6'b000100, 48'h0}) begin n_fail++; $display("FAIL wrap_first: got we=%b wa=%h expected 000100 0", bus.fmap_we, bus.fmap_waddr); end
         end
         if (p == 143) begin
            n_tests++;
            if (bus.fmap_waddr[2*AW +: AW] !== 8'd143) begin n_fail++; $display("FAIL wrap_top: got %0d expected 143", bus.fmap_waddr[2*AW +: AW]); end
         end
         if (p == 144) begin
            n_tests++;
            if (bus.fmap_waddr[2*AW +: AW] !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d expected 0", bus.fmap_waddr[2*AW +: AW]); end
         end
         if (p == 11) begin
            n_tests++;
            if (dut.state_q !== ST_CONV_1) begin n_fail++; $display("FAIL start_ignored: got %0d expected %0d", dut.state_q, ST_CONV_1); end
         end
         tick();
      end
      idle_inputs();
      #1;
      exp_wa = (AW*N_CH)'(5) << (2 * AW);
      n_tests++;
      if (bus.fmap_waddr !== exp_wa) begin n_fail++; $display("FAIL wrap_final: got %h expected %h", bus.fmap_waddr, exp_wa); end
      n_tests++;
      if (dut.state_q !== ST_CONV_1) begin n_fail++; $display("FAIL partial_mask_hold: got %0d expected %0d", dut.state_q, ST_CONV_1); end
      bus.conv_done = 6'b111011;
      tick();
      bus.conv_done = '0;
      #1;
      n_tests++;
      if (dut.state_q !== ST_LOAD_W2) begin n_fail++; $display("FAIL ovalid_done_same_cycle: got %0d expected %0d", dut.state_q, ST_LOAD_W2); end
      rstn = 1'b0;
      #2;
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_staggered();
      state_e exp_st;
      do_start();
      load_weights();
      for (int j = 0; j <= 41; j++) begin
         bus.conv_done = {(j == 40), (j == 7), (j == 40), (j == 2), (j == 9), (j == 5)};
         #1;
         exp_st = (j == 41) ? ST_LOAD_W2 : ST_CONV_1;
         n_tests++;
         if (dut.state_q !== exp_st) begin n_fail++; $display("FAIL stagger[%0d]: got %0d expected %0d", j, dut.state_q, exp_st); end
         tick();
      end
      bus.conv_done = '1;
      for (int j = 0; j < 3; j++) begin
         tick();
         #1;
         n_tests++;
         if ({dut.state_q, bus.din_ready} !== {ST_LOAD_W2, 1'b1}) begin n_fail++; $display("FAIL done_in_load[%0d]: got st=%0d rdy=%b expected st=3 1", j, dut.state_q, bus.din_ready); end
      end
      bus.conv_done = '0;
      tick();
   endtask

   task automatic test_backpressure();
      logic [N_CH-1:0] exp_we;
      int acc;
      acc = 0;
      for (int k = 0; k < 299; k++) begin
         bus.din_valid = (k % 2 == 0);
         #1;
         exp_we = bus.din_valid ? (N_CH'(1) << (acc / 25)) : '0;
         n_tests++;
         if (bus.weight_en !== exp_we) begin n_fail++; $display("FAIL bp_weight_en[%0d]: got %b expected %b", k, bus.weight_en, exp_we); end
         if (bus.din_valid) acc++;
         tick();
      end
      bus.din_valid = 1'b0;
      #1;
      n_tests++;
      if ({dut.state_q, bus.conv_start} !== {ST_CONV_2, 1'b1}) begin n_fail++; $display("FAIL bp_conv2_entry: got st=%0d cs=%b expected st=4 1", dut.state_q, bus.conv_start); end
      tick();
      #1;
      n_tests++;
      if (dut.state_q !== ST_CONV_2) begin n_fail++; $display("FAIL mask_cleared: got %0d expected %0d", dut.state_q, ST_CONV_2); end
   endtask

   task automatic test_reset_mid();
      logic [75:0] outs;
      repeat (3) tick();
      #1;
      n_tests++;
      if ({bus.fmap_rvalid, bus.fmap_raddr} !== {1'b1, 8'd3}) begin n_fail++; $display("FAIL pre_reset_replay: got rv=%b ra=%0d expected 1 3", bus.fmap_rvalid, bus.fmap_raddr); end
      rstn = 1'b0;
      #1;
      outs = {bus.din_ready, bus.weight_en, bus.weight_c, bus.conv_start, bus.conv_layer,
              bus.fmap_we, bus.fmap_waddr, bus.fmap_raddr, bus.fmap_rvalid, bus.fc_start,
              bus.busy, bus.done};
      n_tests++;
      if (outs !== '0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h expected 0", outs); end
      n_tests++;
      if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL mid_reset_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_restart();
      int dn0;
      dn0 = done_pulses;
      do_start();
      load_weights();
      bus.conv_done = '1;
      tick();
      bus.conv_done = '0;
      #1;
      n_tests++;
      if (dut.state_q !== ST_LOAD_W2) begin n_fail++; $display("FAIL restart_w2: got %0d expected %0d", dut.state_q, ST_LOAD_W2); end
      load_weights();
      bus.conv_done = '1;
      tick();
      bus.conv_done = '0;
      bus.fc_done   = 1'b1;
      tick();
      bus.fc_done   = 1'b0;
      #1;
      n_tests++;
      if ({dut.state_q, bus.done} !== {ST_FIN, 1'b1}) begin n_fail++; $display("FAIL restart_fin: got st=%0d done=%b expected st=6 1", dut.state_q, bus.done); end
      tick();
      #1;
      n_tests++;
      if ({dut.state_q, bus.busy} !== {ST_IDLE, 1'b0}) begin n_fail++; $display("FAIL restart_idle: got st=%0d busy=%b expected st=0 0", dut.state_q, bus.busy); end
      n_tests++;
      if (done_pulses - dn0 !== 1) begin n_fail++; $display("FAIL restart_done_count: got %0d expected 1", done_pulses - dn0); end
   endtask

   initial begin
      test_reset();
      test_full();
      test_wrap();
      test_staggered();
      test_backpressure();
      test_reset_mid();
      test_restart();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
